// File: rtl/axis_ask_tx_arbiter_if.sv
// Byte-stream bundle between NUM_SRC requesters and the shared ASK UART TX
// wrapper.
//
// Handshake: a byte moves on a rising clk edge exactly when valid and ready
// are both high on that edge. A source holds tdata/tlast stable while valid
// is high and ready is low. tlast marks the final byte of a message.
interface axis_ask_tx_arbiter_if #(
  parameter int NUM_SRC = 2
);
  logic [8*NUM_SRC-1:0] s_tdata;
  logic [NUM_SRC-1:0]   s_tvalid;
  logic [NUM_SRC-1:0]   s_tlast;
  logic [NUM_SRC-1:0]   s_tready;
  logic [7:0]           m_tdata;
  logic                 m_tvalid;
  logic                 m_tready;

  // Arbiter view: consumes requester streams, drives the wrapper stream.
  modport slave (
    input  s_tdata, s_tvalid, s_tlast, m_tready,
    output s_tready, m_tdata, m_tvalid
  );

  // Environment view: requesters plus the wrapper's ready.
  modport master (
    output s_tdata, s_tvalid, s_tlast, m_tready,
    input  s_tready, m_tdata, m_tvalid
  );
endinterface

// File: rtl/axis_ask_tx_arbiter.sv
// Round-robin arbiter sharing one ASK UART TX between NUM_SRC byte streams.
// An owner keeps the link until its tlast or MAX_BURST accepted bytes, then
// the link is held idle for GUARD_CYCLES so the receiver can settle.
module axis_ask_tx_arbiter #(
  parameter int NUM_SRC      = 2,
  parameter int MAX_BURST    = 16,
  parameter int GUARD_CYCLES = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  axis_ask_tx_arbiter_if.slave   bus,
  output logic [NUM_SRC-1:0]     grant,
  output logic                   busy,
  output logic [1:0]             o_dbg_state
);

  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GUARD = 2'd2
  } state_t;

  state_t             r_state;
  logic [IW-1:0]      r_owner;
  logic [IW-1:0]      r_last_owner;
  logic [7:0]         r_beat_cnt;
  logic [9:0]         r_guard_cnt;
  logic [NUM_SRC-1:0] r_grant;

  logic               w_found;
  logic [IW-1:0]      w_pick;
  logic               w_in_grant;
  logic [7:0]         w_own_data;
  logic               w_own_valid;
  logic               w_own_last;
  logic [NUM_SRC-1:0] w_s_tready;
  logic               w_beat;
  logic               w_cap;
  logic               w_release;

  // Round-robin search starting just after the previous owner.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        if (!w_found && bus.s_tvalid[k] &&
            (((int'(r_last_owner) + i) % NUM_SRC) == k)) begin
          w_found = 1'b1;
          w_pick  = IW'(k);
        end
      end
    end
  end

  // Select the owner's stream and steer m_tready back to it only.
  always_comb begin
    w_own_data  = 8'h00;
    w_own_valid = 1'b0;
    w_own_last  = 1'b0;
    w_s_tready  = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (r_owner == IW'(k)) begin
        w_own_data    = bus.s_tdata[8*k +: 8];
        w_own_valid   = bus.s_tvalid[k];
        w_own_last    = bus.s_tlast[k];
        w_s_tready[k] = w_in_grant & bus.m_tready;
      end
    end
  end

  assign w_in_grant   = (r_state == ST_GRANT);
  assign bus.m_tvalid = w_in_grant & w_own_valid;
  assign bus.m_tdata  = w_in_grant ? w_own_data : 8'h00;
  assign bus.s_tready = w_s_tready;

  // tlast and the burst cap landing on the same beat release only once.
  assign w_beat    = w_in_grant & w_own_valid & bus.m_tready;
  assign w_cap     = (({1'b0, r_beat_cnt} + 9'd1) == 9'(MAX_BURST));
  assign w_release = w_beat & (w_own_last | w_cap);

  assign grant       = r_grant;
  assign busy        = (r_state != ST_IDLE);
  assign o_dbg_state = r_state;

  // Arbitration FSM: IDLE picks an owner, GRANT streams it, GUARD idles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_owner      <= '0;
      r_last_owner <= IW'(NUM_SRC - 1);
      r_beat_cnt   <= 8'd0;
      r_guard_cnt  <= 10'd0;
      r_grant      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_owner    <= w_pick;
            r_grant    <= {{(NUM_SRC-1){1'b0}}, 1'b1} << w_pick;
            r_beat_cnt <= 8'd0;
            r_state    <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (w_beat) begin
            r_beat_cnt <= r_beat_cnt + 8'd1;
          end
          if (w_release) begin
            r_last_owner <= r_owner;
            r_grant      <= '0;
            r_guard_cnt  <= 10'd0;
            r_state      <= (GUARD_CYCLES == 0) ? ST_IDLE : ST_GUARD;
          end
        end
        ST_GUARD: begin
          if (r_guard_cnt == 10'(GUARD_CYCLES - 1)) begin
            r_state <= ST_IDLE;
          end else begin
            r_guard_cnt <= r_guard_cnt + 10'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_ask_tx_arbiter.sv
// Bench for axis_ask_tx_arbiter: two requesters, MAX_BURST=4, GUARD_CYCLES=32.
// Directed messages with hand-ordered expected beats in a scoreboard queue.
module tb_axis_ask_tx_arbiter;

  localparam int NS = 2;
  localparam int MB = 4;
  localparam int GC = 32;
  localparam int W  = NS + 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axis_ask_tx_arbiter_if #(.NUM_SRC(NS)) bus ();
  logic [NS-1:0] grant;
  logic          busy;
  logic [1:0]    dbg_state;

  axis_ask_tx_arbiter #(
    .NUM_SRC(NS), .MAX_BURST(MB), .GUARD_CYCLES(GC)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .grant(grant), .busy(busy), .o_dbg_state(dbg_state)
  );

  // ---------------- bench state ----------------
  logic [W-1:0] exp_q[$];    // {grant, m_tdata} per accepted beat
  int           guard_q[$];  // expected guard lengths in cycles
  logic [8:0]   q0[$];       // {tlast, tdata} still to send, source 0
  logic [8:0]   q1[$];       // same, source 1
  int           tests = 0;
  int           fails = 0;
  int           beats_seen = 0;
  logic         pause0 = 1'b0;
  logic         bp_en  = 1'b0;
  logic [3:0]   bp_pat = 4'b1001;  // m_tready sequence 1,0,0,1

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send(input int src, input logic [7:0] d, input logic last);
    if (src == 0) q0.push_back({last, d});
    else          q1.push_back({last, d});
  endtask

  task automatic exp_beat(input int src, input logic [7:0] d);
    logic [NS-1:0] g;
    g      = '0;
    g[src] = 1'b1;
    exp_q.push_back({g, d});
  endtask

  // ---------------- driver: sources and wrapper ready ----------------
  initial begin : driver
    logic [NS-1:0] hs;
    int bp_idx;
    bp_idx       = 0;
    bus.s_tvalid = '0;
    bus.s_tdata  = '0;
    bus.s_tlast  = '0;
    bus.m_tready = 1'b1;
    forever begin
      @(negedge clk);
      hs = bus.s_tvalid & bus.s_tready;
      @(posedge clk);
      #1;
      if (hs[0] && q0.size() > 0) void'(q0.pop_front());
      if (hs[1] && q1.size() > 0) void'(q1.pop_front());
      if (bp_en) begin
        bus.m_tready = bp_pat[bp_idx];
        bp_idx = (bp_idx + 1) % 4;
      end else begin
        bus.m_tready = 1'b1;
        bp_idx = 0;
      end
      bus.s_tvalid[0]  = (q0.size() > 0) && !pause0;
      bus.s_tdata[7:0] = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
      bus.s_tlast[0]   = (q0.size() > 0) ? q0[0][8] : 1'b0;
      bus.s_tvalid[1]  = (q1.size() > 0);
      bus.s_tdata[15:8] = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
      bus.s_tlast[1]   = (q1.size() > 0) ? q1[0][8] : 1'b0;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    int gcnt;
    logic [W-1:0] e;
    gcnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        gcnt = 0;
      end else begin
        if (bus.m_tvalid && bus.m_tready) begin
          beats_seen++;
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL beat: unexpected byte %0h grant %0b, none required", bus.m_tdata, grant);
          end else begin
            e = exp_q.pop_front();
            chk("beat", {grant, bus.m_tdata}, e);
          end
        end
        chk("s_tready", bus.s_tready, grant & {NS{bus.m_tready}});
        if (busy && grant == '0) begin
          gcnt++;
        end else if (gcnt != 0) begin
          if (guard_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL guard: unexpected guard of %0d cycles, none required", gcnt);
          end else begin
            chk("guard_len", gcnt, guard_q.pop_front());
          end
          gcnt = 0;
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic do_reset();
    rst    = 1'b1;
    pause0 = 1'b0;
    bp_en  = 1'b0;
    q0.delete(); q1.delete(); exp_q.delete(); guard_q.delete();
    repeat (3) @(negedge clk);
    chk("rst_grant",  grant, 0);
    chk("rst_busy",   busy, 0);
    chk("rst_mvalid", bus.m_tvalid, 0);
    chk("rst_mdata",  bus.m_tdata, 0);
    chk("rst_sready", bus.s_tready, 0);
    rst = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || guard_q.size() != 0 || q0.size() != 0 ||
            q1.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", (n >= budget), 0);
    chk("drain_left", exp_q.size(), 0);
    @(negedge clk);
  endtask

  // ---------------- directed tests ----------------
  initial begin : stim
    int n;
    int base;

    // Single source, three bytes, one guard.
    do_reset();
    send(0, 8'h55, 0); send(0, 8'hAA, 0); send(0, 8'hFF, 1);
    exp_beat(0, 8'h55); exp_beat(0, 8'hAA); exp_beat(0, 8'hFF);
    guard_q.push_back(GC);
    @(negedge clk);
    chk("lat_idle_mvalid", bus.m_tvalid, 0);
    @(negedge clk);
    chk("lat_first_mvalid", bus.m_tvalid, 1);
    chk("lat_first_grant", grant, 2'b01);
    chk("lat_state", dbg_state, 1);
    wait_drain(300);

    // Contention: strict alternation, src0 first after reset.
    do_reset();
    send(0, 8'h11, 0); send(0, 8'h12, 1); send(0, 8'h13, 1);
    send(1, 8'h21, 0); send(1, 8'h22, 1); send(1, 8'h23, 1);
    exp_beat(0, 8'h11); exp_beat(0, 8'h12);
    exp_beat(1, 8'h21); exp_beat(1, 8'h22);
    exp_beat(0, 8'h13);
    exp_beat(1, 8'h23);
    repeat (4) guard_q.push_back(GC);
    wait_drain(800);

    // Burst cap of 4: src0 truncated, src1 served, src0 resumes at byte 5.
    do_reset();
    for (int i = 0; i < 10; i++) send(0, 8'(i), (i == 9));
    send(1, 8'hA0, 0); send(1, 8'hA1, 0); send(1, 8'hA2, 1);
    for (int i = 0; i < 4; i++) exp_beat(0, 8'(i));
    exp_beat(1, 8'hA0); exp_beat(1, 8'hA1); exp_beat(1, 8'hA2);
    for (int i = 4; i < 10; i++) exp_beat(0, 8'(i));
    repeat (4) guard_q.push_back(GC);
    wait_drain(1000);

    // Backpressure, owner pausing valid, tlast coinciding with the cap.
    do_reset();
    bp_en = 1'b1;
    send(0, 8'h31, 0); send(0, 8'h32, 0); send(0, 8'h33, 0); send(0, 8'h34, 1);
    send(1, 8'h41, 0); send(1, 8'h42, 1);
    exp_beat(0, 8'h31); exp_beat(0, 8'h32); exp_beat(0, 8'h33); exp_beat(0, 8'h34);
    exp_beat(1, 8'h41); exp_beat(1, 8'h42);
    repeat (2) guard_q.push_back(GC);
    n = 0;
    while (grant != 2'b01 && n < 50) begin @(negedge clk); n++; end
    chk("bp_grant_timeout", (n >= 50), 0);
    repeat (2) @(negedge clk);
    pause0 = 1'b1;
    repeat (3) @(negedge clk);
    chk("pause_grant_held", grant, 2'b01);
    pause0 = 1'b0;
    wait_drain(600);
    bp_en = 1'b0;

    // Asynchronous reset mid-grant, then src0 must win again.
    do_reset();
    send(0, 8'h51, 1);
    for (int i = 1; i <= 8; i++) send(0, 8'(8'h60 + i), (i == 8));
    exp_beat(0, 8'h51); exp_beat(0, 8'h61); exp_beat(0, 8'h62);
    guard_q.push_back(GC);
    base = beats_seen;
    n = 0;
    while (beats_seen < base + 3 && n < 200) begin @(negedge clk); n++; end
    chk("pre_rst_timeout", (n >= 200), 0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_grant",  grant, 0);
    chk("arst_mvalid", bus.m_tvalid, 0);
    chk("arst_busy",   busy, 0);
    q0.delete(); q1.delete();
    chk("arst_abandon", exp_q.size(), 0);
    exp_q.delete(); guard_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    send(0, 8'h71, 1);
    send(1, 8'h81, 1);
    exp_beat(0, 8'h71);
    exp_beat(1, 8'h81);
    repeat (2) guard_q.push_back(GC);
    wait_drain(400);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin : watchdog
    #500000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached, still running");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axis_ask_tx_arbiter.md
AXIS_ASK_TX_ARBITER -- requirements
Module: axis_ask_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_SRC, default 2, number of AXI-Stream requesters (2..8).
REQ-002 SHALL have parameter MAX_BURST, default 16, maximum bytes per grant before forced rotation (1..255).
REQ-003 SHALL have parameter GUARD_CYCLES, default 32, idle cycles inserted after each grant so the receive integrator and detector settle (0..1023).
REQ-004 SHALL have port clk  input  1  single clock.
REQ-005 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-006 SHALL have port s_tdata  input  8*NUM_SRC  requester bytes; source k occupies bits [8k+7:8k].
REQ-007 SHALL have port s_tvalid  input  NUM_SRC  per-source valid.
REQ-008 SHALL have port s_tlast  input  NUM_SRC  per-source end-of-message.
REQ-009 SHALL have port s_tready  output  NUM_SRC  per-source ready.
REQ-010 SHALL have port m_tdata  output  8  byte to the shared ASK UART TX wrapper i_tdata.
REQ-011 SHALL have port m_tvalid  output  1  to wrapper i_tvalid.
REQ-012 SHALL have port m_tready  input  1  from wrapper i_tready.
REQ-013 SHALL have port grant  output  NUM_SRC  one-hot current owner; all-zero when unowned.
REQ-014 SHALL have port busy  output  1  high in GRANT or GUARD.

Function
REQ-015 SHALL implement FSM states IDLE, GRANT, GUARD.
REQ-016 IDLE: if any s_tvalid is high, SHALL select the first valid source searching round-robin from (last_owner+1) mod NUM_SRC, register it as owner, and enter GRANT on the next edge; else SHALL remain in IDLE.
REQ-017 SHALL make the arbitration decision in one cycle: first m_tvalid at the earliest one cycle after the winning s_tvalid rises in IDLE.
REQ-018 GRANT: m_tdata/m_tvalid SHALL pass combinationally from the owner; s_tready[owner] = m_tready; all other s_tready SHALL be 0.
REQ-019 Outside GRANT: m_tvalid SHALL be 0, all s_tready 0, m_tdata 8'h00.
REQ-020 SHALL count accepted beats (m_tvalid & m_tready) per grant in an 8-bit counter cleared on entry to GRANT.
REQ-021 GRANT SHALL end on the accepted beat with s_tlast[owner]=1 or on the beat that brings the count to MAX_BURST, whichever comes first; next state GUARD (or IDLE if GUARD_CYCLES=0).
REQ-022 An owner dropping s_tvalid mid-message SHALL NOT release the grant; the grant holds until REQ-021.
REQ-023 GUARD: a 10-bit counter SHALL run GUARD_CYCLES cycles, then go to IDLE; requests are ignored during GUARD.
REQ-024 last_owner SHALL update on every exit from GRANT, so a source truncated by MAX_BURST loses priority to any other pending source.
REQ-025 With a single requester continuously valid, that source SHALL be re-granted after each GUARD.
REQ-026 Simultaneous tlast and MAX_BURST on one beat SHALL cause a single release, not two.
REQ-027 grant SHALL be registered, one-hot, and equal to owner exactly while in GRANT.

Reset
REQ-028 On rst assertion, regardless of clock, SHALL enter IDLE, set last_owner = NUM_SRC-1 (source 0 wins first), and clear both counters.
REQ-029 During and after reset: grant=0, busy=0, m_tvalid=0, m_tdata=8'h00, s_tready=0.
REQ-030 Reset mid-GRANT SHALL drop m_tvalid immediately; the partially sent message is abandoned with no replay.

Verification
REQ-031 Single source: src0 sends 3 bytes 8'h55,8'hAA,8'hFF with tlast on the third, m_tready=1 -> m_tdata sequence 55,AA,FF, grant=01 for 3 cycles, then busy high 32 cycles in GUARD, then IDLE.
REQ-032 Contention: src0 and src1 both valid in IDLE after reset -> src0 granted first; after its tlast+GUARD, src1 granted; with both re-requesting, src0 next (strict alternation).
REQ-033 Burst cap: MAX_BURST=4, src0 sends 10 bytes, src1 pending -> 4 bytes from src0, GUARD, src1 message, GUARD, src0 resumes at byte 5.
REQ-034 Backpressure: m_tready toggles 1,0,0,1 per UART byte period -> no byte lost or duplicated; s_tready[owner] mirrors m_tready; non-owner s_tready stays 0.
REQ-035 Async reset: assert rst mid-GRANT between clock edges -> grant, m_tvalid, busy fall before next edge; after release, src0 wins the next arbitration.
REQ-036 Edge case: single-byte message with tlast on the beat where count=MAX_BURST=1 -> exactly one GUARD period, last_owner updated once.
